// File: rtl/mem_lsu_pkg.sv
// Shared op codes, exception codes, FSM states and decode helpers for the load/store unit.
package mem_lsu_pkg;

  localparam int ALUOP_W   = 8;
  localparam int REGADDR_W = 5;

  // Op layout: [7:4]=4'h2 marks a memory op, [3]=store, [2]=zero-extend, [1:0]=log2(bytes)
  typedef enum logic [ALUOP_W-1:0] {
    OP_LB  = 8'h20, OP_LH  = 8'h21, OP_LW  = 8'h22, OP_LD  = 8'h23,
    OP_LBU = 8'h24, OP_LHU = 8'h25, OP_LWU = 8'h26,
    OP_SB  = 8'h28, OP_SH  = 8'h29, OP_SW  = 8'h2A, OP_SD  = 8'h2B
  } aluop_e;

  localparam logic [31:0] EXC_NONE           = 32'd0;
  localparam logic [31:0] EXC_ILLEGAL_INSN   = 32'd2;
  localparam logic [31:0] EXC_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] EXC_LOAD_FAULT     = 32'd5;
  localparam logic [31:0] EXC_STORE_MISALIGN = 32'd6;
  localparam logic [31:0] EXC_STORE_FAULT    = 32'd7;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT_R, ST_DRAIN, ST_DONE} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_t;

  function automatic logic op_is_mem(input logic [ALUOP_W-1:0] op);
    return (op[7:4] == 4'h2) && !(op[2] && (op[3] || (op[1:0] == 2'b11)));
  endfunction

  function automatic logic op_is_store(input logic [ALUOP_W-1:0] op);
    return op[3];
  endfunction

  function automatic logic op_is_unsigned(input logic [ALUOP_W-1:0] op);
    return op[2];
  endfunction

  function automatic mem_size_t op_size(input logic [ALUOP_W-1:0] op);
    return mem_size_t'(op[1:0]);
  endfunction

  function automatic logic misaligned(input mem_size_t sz, input logic [2:0] a);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      SZ_W:    return |a[1:0];
      default: return |a;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian lane steering: byte-select generation, store replication and load
// extraction with sign/zero extension. Byte offset k lives in bits [XLEN-1-8k -: 8].
module mem_lsu_align import mem_lsu_pkg::*; #(
  parameter  int XLEN   = 32,
  localparam int NBYTES = XLEN / 8,
  localparam int OFFW   = $clog2(NBYTES)
) (
  input  mem_size_t         size_i,
  input  logic              unsigned_i,
  input  logic [OFFW-1:0]   off_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [NBYTES-1:0] sel_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   ldata_o
);

  localparam logic [7:0] XW = 8'(XLEN);

  logic [3:0]      lanes;
  logic [7:0]      nbits;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] fill;

  always_comb begin
    lanes = 4'd1 << size_i;
    nbits = 8'd8 << size_i;
    if (nbits > XW) nbits = XW;

    // Top-aligned mask slid down to the addressed lane
    sel_o = (~({NBYTES{1'b1}} >> lanes)) >> off_i;

    case (size_i)
      SZ_B:    wdata_o = {(XLEN/8){wdata_i[7:0]}};
      SZ_H:    wdata_o = {(XLEN/16){wdata_i[15:0]}};
      SZ_W:    wdata_o = {(XLEN/32){wdata_i[31:0]}};
      default: wdata_o = wdata_i;
    endcase

    // Move the addressed field to the top, then right-justify it
    sh      = rdata_i << {off_i, 3'b000};
    fill    = (!unsigned_i && sh[XLEN-1]) ? ({XLEN{1'b1}} << nbits) : '0;
    ldata_o = (sh >> (XW - nbits)) | fill;
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding data-bus access, alignment and legality checks,
// flush/drain handling and a one-cycle completion pulse to writeback.
module mem_lsu import mem_lsu_pkg::*; #(
  parameter  int XLEN   = 32,
  localparam int NBYTES = XLEN / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  input  logic [ALUOP_W-1:0]   aluop_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic                 flush_i,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [XLEN-1:0]      bus_addr_o,
  output logic [NBYTES-1:0]    bus_sel_o,
  output logic [XLEN-1:0]      bus_wdata_o,
  input  logic                 bus_gnt_i,
  input  logic                 bus_rvalid_i,
  input  logic [XLEN-1:0]      bus_rdata_i,
  input  logic                 bus_err_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [XLEN-1:0]      wdata_o,
  output logic [31:0]          excepttype_o,
  output logic [XLEN-1:0]      badaddr_o
);

  localparam int OFFW = $clog2(NBYTES);

  lsu_state_t           state_q;
  logic [ALUOP_W-1:0]   op_q;
  logic [XLEN-1:0]      addr_q;
  logic [XLEN-1:0]      sdata_q;
  logic [REGADDR_W-1:0] wd_q;
  logic                 wreg_q;
  logic [31:0]          exc_q;
  logic [XLEN-1:0]      res_q;

  mem_size_t            req_size;
  logic [31:0]          req_exc;
  logic                 accept;
  logic [NBYTES-1:0]    lane_sel;
  logic [XLEN-1:0]      lane_wdata;
  logic [XLEN-1:0]      lane_ldata;

  always_comb begin
    req_size = op_size(aluop_i);
    req_exc  = EXC_NONE;
    if (XLEN == 32 && (req_size == SZ_D || (req_size == SZ_W && op_is_unsigned(aluop_i))))
      req_exc = EXC_ILLEGAL_INSN;
    else if (misaligned(req_size, addr_i[2:0]))
      req_exc = op_is_store(aluop_i) ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
  end

  assign accept = (state_q == ST_IDLE) && req_valid_i && op_is_mem(aluop_i) && !flush_i;

  mem_lsu_align #(.XLEN(XLEN)) u_align (
    .size_i     (op_size(op_q)),
    .unsigned_i (op_is_unsigned(op_q)),
    .off_i      (addr_q[OFFW-1:0]),
    .wdata_i    (sdata_q),
    .rdata_i    (bus_rdata_i),
    .sel_o      (lane_sel),
    .wdata_o    (lane_wdata),
    .ldata_o    (lane_ldata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      exc_q   <= EXC_NONE;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= aluop_i;
            addr_q  <= addr_i;
            sdata_q <= wdata_i;
            wd_q    <= wd_i;
            wreg_q  <= wreg_i && !op_is_store(aluop_i);
            exc_q   <= req_exc;
            res_q   <= '0;
            state_q <= (req_exc != EXC_NONE) ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            if (op_is_store(op_q)) begin
              exc_q   <= bus_err_i ? EXC_STORE_FAULT : EXC_NONE;
              state_q <= flush_i ? ST_IDLE : ST_DONE;
            end else begin
              state_q <= flush_i ? ST_DRAIN : ST_WAIT_R;
            end
          end else if (flush_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_R: begin
          // A flush coinciding with the response has nothing left to drain
          if (flush_i) begin
            state_q <= bus_rvalid_i ? ST_IDLE : ST_DRAIN;
          end else if (bus_rvalid_i) begin
            res_q   <= lane_ldata;
            if (bus_err_i) exc_q <= EXC_LOAD_FAULT;
            state_q <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (bus_rvalid_i) state_q <= ST_IDLE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_req_o   = (state_q == ST_REQ);
  assign bus_we_o    = bus_req_o && op_is_store(op_q);
  assign bus_addr_o  = bus_req_o ? addr_q : '0;
  assign bus_sel_o   = bus_req_o ? lane_sel : '0;
  assign bus_wdata_o = bus_we_o ? lane_wdata : '0;

  // Gated by rst because the IDLE term looks straight at the request inputs
  assign stall_o = rst && ((state_q == ST_REQ) || (state_q == ST_WAIT_R) || accept);

  assign done_o       = (state_q == ST_DONE) && !flush_i;
  assign wreg_o       = done_o && wreg_q && (exc_q == EXC_NONE);
  assign wd_o         = done_o ? wd_q : '0;
  assign wdata_o      = done_o ? res_q : '0;
  assign excepttype_o = done_o ? exc_q : '0;
  assign badaddr_o    = (done_o && exc_q != EXC_NONE) ? addr_q : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: XLEN=32 instance for protocol/exception/flush/reset
// scenarios, plus an XLEN=64 instance for doubleword and word-extension lanes.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        req_valid, wreg, flush, gnt, rvalid, err;
  logic [7:0]  aluop;
  logic [31:0] addr, wdata, rdata;
  logic [4:0]  wd;
  logic        bus_req, bus_we, stall, done, wreg_out;
  logic [31:0] bus_addr, bus_wdata, wdata_out, exc, badaddr;
  logic [3:0]  bus_sel;
  logic [4:0]  wd_out;

  logic        req_valid6, gnt6, rvalid6;
  logic [7:0]  aluop6;
  logic [63:0] addr6, rdata6;
  logic        bus_req6, bus_we6, stall6, done6, wreg_out6;
  logic [63:0] bus_addr6, bus_wdata6, wdata_out6, badaddr6;
  logic [31:0] exc6;
  logic [7:0]  bus_sel6;
  logic [4:0]  wd_out6;

  mem_lsu #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .aluop_i(aluop), .addr_i(addr),
    .wdata_i(wdata), .wd_i(wd), .wreg_i(wreg), .flush_i(flush),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_sel_o(bus_sel),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_rdata_i(rdata),
    .bus_err_i(err), .stall_o(stall), .done_o(done), .wd_o(wd_out), .wreg_o(wreg_out),
    .wdata_o(wdata_out), .excepttype_o(exc), .badaddr_o(badaddr)
  );

  mem_lsu #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid6), .aluop_i(aluop6), .addr_i(addr6),
    .wdata_i(64'd0), .wd_i(5'd3), .wreg_i(1'b1), .flush_i(1'b0),
    .bus_req_o(bus_req6), .bus_we_o(bus_we6), .bus_addr_o(bus_addr6), .bus_sel_o(bus_sel6),
    .bus_wdata_o(bus_wdata6), .bus_gnt_i(gnt6), .bus_rvalid_i(rvalid6), .bus_rdata_i(rdata6),
    .bus_err_i(1'b0), .stall_o(stall6), .done_o(done6), .wd_o(wd_out6), .wreg_o(wreg_out6),
    .wdata_o(wdata_out6), .excepttype_o(exc6), .badaddr_o(badaddr6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; aluop = op; addr = a; wdata = d; wd = 5'd7; wreg = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b1; aluop = OP_LW; addr = 32'h100; wdata = '0; wd = '0; wreg = 1'b1;
    flush = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
    req_valid6 = 1'b0; aluop6 = '0; addr6 = '0; gnt6 = 1'b0; rvalid6 = 1'b0; rdata6 = '0;
    @(negedge clk);
    vectors++;
    if ({bus_req, stall, done, wreg_out, exc, wdata_out, bus_sel} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b stall=%b done=%b wreg=%b exc=%h data=%h sel=%b, want all 0",
               bus_req, stall, done, wreg_out, exc, wdata_out, bus_sel);
    end
    vectors++;
    if ({bus_req6, stall6, done6, exc6} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs64: got req=%b stall=%b done=%b exc=%h, want all 0", bus_req6, stall6, done6, exc6);
    end
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic do_load32(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] rd, input logic [3:0] exp_sel, input logic [31:0] exp_data);
    present(op, a, 32'h0);
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL %s accept_stall: got %b, want 1", name, stall);
    end
    step();
    req_valid = 1'b0; gnt = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus_req, bus_we, bus_sel, bus_addr} !== {1'b1, 1'b0, exp_sel, a}) begin
      miscompares++;
      $display("FAIL %s request: got req=%b we=%b sel=%b addr=%h, want 1 0 %b %h", name, bus_req, bus_we, bus_sel, bus_addr, exp_sel, a);
    end
    step();
    gnt = 1'b0; rvalid = 1'b1; rdata = rd;
    @(negedge clk);
    vectors++;
    if ({bus_req, stall, done} !== 3'b010) begin
      miscompares++; $display("FAIL %s wait_r: got req=%b stall=%b done=%b, want 0 1 0", name, bus_req, stall, done);
    end
    step();
    rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({done, wreg_out, stall, wd_out, exc, wdata_out} !== {1'b1, 1'b1, 1'b0, 5'd7, 32'h0, exp_data}) begin
      miscompares++;
      $display("FAIL %s done: got done=%b wreg=%b stall=%b wd=%0d exc=%h data=%h, want 1 1 0 7 0 %h",
               name, done, wreg_out, stall, wd_out, exc, wdata_out, exp_data);
    end
    step();
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL %s done_width: got %b after completion, want 0", name, done);
    end
  endtask

  task automatic do_store32(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                            input int nwait, input logic e, input logic [3:0] exp_sel, input logic [31:0] exp_wd);
    present(op, a, d);
    step();
    req_valid = 1'b0;
    for (int i = 0; i <= nwait; i++) begin
      gnt = (i == nwait); err = (i == nwait) && e;
      @(negedge clk);
      vectors++;
      if ({bus_req, bus_we, stall, bus_sel, bus_addr, bus_wdata} !== {3'b111, exp_sel, a, exp_wd}) begin
        miscompares++;
        $display("FAIL %s req_cycle%0d: got req=%b we=%b stall=%b sel=%b addr=%h wd=%h, want 1 1 1 %b %h %h",
                 name, i, bus_req, bus_we, stall, bus_sel, bus_addr, bus_wdata, exp_sel, a, exp_wd);
      end
      step();
    end
    gnt = 1'b0; err = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus_req, done, wreg_out, exc, badaddr} !== {1'b0, 1'b1, 1'b0, (e ? EXC_STORE_FAULT : EXC_NONE), (e ? a : 32'h0)}) begin
      miscompares++;
      $display("FAIL %s done: got req=%b done=%b wreg=%b exc=%h bad=%h, want 0 1 0 %h %h",
               name, bus_req, done, wreg_out, exc, badaddr, (e ? EXC_STORE_FAULT : EXC_NONE), (e ? a : 32'h0));
    end
    step();
  endtask

  task automatic do_exc32(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] exp_exc);
    present(op, a, 32'h5555_AAAA);
    @(negedge clk);
    vectors++;
    if ({stall, bus_req} !== 2'b10) begin
      miscompares++; $display("FAIL %s accept: got stall=%b req=%b, want 1 0", name, stall, bus_req);
    end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({done, bus_req, wreg_out, exc, badaddr} !== {1'b1, 1'b0, 1'b0, exp_exc, a}) begin
      miscompares++;
      $display("FAIL %s done: got done=%b req=%b wreg=%b exc=%h bad=%h, want 1 0 0 %h %h",
               name, done, bus_req, wreg_out, exc, badaddr, exp_exc, a);
    end
    step();
  endtask

  task automatic test_loads();
    do_load32("lb_0x103", OP_LB,  32'h103, 32'h0000_00F0, 4'b0001, 32'hFFFF_FFF0);
    do_load32("lbu_0x100", OP_LBU, 32'h100, 32'h8012_3456, 4'b1000, 32'h0000_0080);
    do_load32("lh_0x102", OP_LH,  32'h102, 32'h0000_8001, 4'b0011, 32'hFFFF_8001);
    do_load32("lhu_0x000", OP_LHU, 32'h000, 32'h8001_0000, 4'b1100, 32'h0000_8001);
    do_load32("lw_0x104", OP_LW,  32'h104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
  endtask

  task automatic test_stores();
    do_store32("sh_wait", OP_SH, 32'h202, 32'h1234_ABCD, 2, 1'b0, 4'b0011, 32'hABCD_ABCD);
    do_store32("sb_0x101", OP_SB, 32'h101, 32'h0000_005A, 0, 1'b0, 4'b0100, 32'h5A5A_5A5A);
    do_store32("sw_fault", OP_SW, 32'h300, 32'hCAFE_F00D, 1, 1'b1, 4'b1111, 32'hCAFE_F00D);
  endtask

  task automatic test_exceptions();
    do_exc32("lw_mis", OP_LW, 32'h101, EXC_LOAD_MISALIGN);
    do_exc32("lh_mis", OP_LH, 32'h201, EXC_LOAD_MISALIGN);
    do_exc32("sw_mis", OP_SW, 32'h302, EXC_STORE_MISALIGN);
    do_exc32("sh_mis", OP_SH, 32'h303, EXC_STORE_MISALIGN);
    do_exc32("ld_ill", OP_LD, 32'h008, EXC_ILLEGAL_INSN);
    do_exc32("lwu_ill", OP_LWU, 32'h100, EXC_ILLEGAL_INSN);
    do_exc32("sd_ill", OP_SD, 32'h000, EXC_ILLEGAL_INSN);
    // Load whose response carries an error
    present(OP_LW, 32'h100, 32'h0);
    step();
    req_valid = 1'b0; gnt = 1'b1;
    step();
    gnt = 1'b0; rvalid = 1'b1; err = 1'b1; rdata = 32'h1111_1111;
    step();
    rvalid = 1'b0; err = 1'b0;
    @(negedge clk);
    vectors++;
    if ({done, wreg_out, exc, badaddr} !== {1'b1, 1'b0, EXC_LOAD_FAULT, 32'h100}) begin
      miscompares++;
      $display("FAIL lw_fault: got done=%b wreg=%b exc=%h bad=%h, want 1 0 00000005 00000100", done, wreg_out, exc, badaddr);
    end
    step();
  endtask

  task automatic test_flush();
    // WAIT_R flush: drain the late response, no completion
    present(OP_LW, 32'h104, 32'h0);
    step();
    req_valid = 1'b0; gnt = 1'b1;
    step();
    gnt = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    vectors++;
    if ({stall, done, bus_req} !== 3'b000) begin
      miscompares++; $display("FAIL flush_wait_r drain: got stall=%b done=%b req=%b, want 0 0 0", stall, done, bus_req);
    end
    step();
    rvalid = 1'b1; rdata = 32'h7777_7777;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL flush_wait_r rvalid: got done=%b, want 0", done);
    end
    step();
    rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({done, stall} !== 2'b00) begin
      miscompares++; $display("FAIL flush_wait_r after: got done=%b stall=%b, want 0 0", done, stall);
    end
    do_load32("after_drain", OP_LB, 32'h101, 32'h0012_3400, 4'b0100, 32'h0000_0012);

    // REQ flush before grant: request dropped, stray responses ignored
    present(OP_LW, 32'h108, 32'h0);
    step();
    req_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; gnt = 1'b1; rvalid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus_req, stall, done} !== 3'b000) begin
      miscompares++; $display("FAIL flush_req: got req=%b stall=%b done=%b, want 0 0 0", bus_req, stall, done);
    end
    step();
    gnt = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL flush_req stray: got done=%b, want 0", done);
    end

    // REQ flush with grant on a load: DRAIN, then IDLE without completion
    present(OP_LW, 32'h10C, 32'h0);
    step();
    req_valid = 1'b0; gnt = 1'b1; flush = 1'b1;
    step();
    gnt = 1'b0; flush = 1'b0;
    @(negedge clk);
    vectors++;
    if ({stall, done, bus_req} !== 3'b000) begin
      miscompares++; $display("FAIL flush_gnt drain: got stall=%b done=%b req=%b, want 0 0 0", stall, done, bus_req);
    end
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL flush_gnt after: got done=%b, want 0", done);
    end

    // DONE flush suppresses the completion pulse
    present(OP_LW, 32'h101, 32'h0);
    step();
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    vectors++;
    if ({done, wreg_out} !== 2'b00) begin
      miscompares++; $display("FAIL flush_done: got done=%b wreg=%b, want 0 0", done, wreg_out);
    end
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    present(OP_LW, 32'h100, 32'h0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus_req !== 1'b1) begin
      miscompares++; $display("FAIL rst_req pre: got req=%b, want 1", bus_req);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({bus_req, stall} !== 2'b00) begin
      miscompares++; $display("FAIL rst_req async: got req=%b stall=%b, want 0 0", bus_req, stall);
    end
    step();
    rst = 1'b1;

    present(OP_LW, 32'h100, 32'h0);
    step();
    req_valid = 1'b0; gnt = 1'b1;
    step();
    gnt = 1'b0;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL rst_wait_r pre: got stall=%b, want 1", stall);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({bus_req, stall, done, exc} !== '0) begin
      miscompares++; $display("FAIL rst_wait_r async: got req=%b stall=%b done=%b exc=%h, want 0", bus_req, stall, done, exc);
    end
    step();
    rst = 1'b1;
    rvalid = 1'b1; rdata = 32'h1234_5678;
    step();
    rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({done, stall} !== 2'b00) begin
        miscompares++; $display("FAIL rst_late_rvalid c%0d: got done=%b stall=%b, want 0 0", i, done, stall);
      end
      step();
    end
  endtask

  task automatic do_load64(input string name, input logic [7:0] op, input logic [63:0] a,
                           input logic [63:0] rd, input logic [7:0] exp_sel, input logic [63:0] exp_data);
    req_valid6 = 1'b1; aluop6 = op; addr6 = a;
    step();
    req_valid6 = 1'b0; gnt6 = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus_req6, bus_sel6, bus_addr6} !== {1'b1, exp_sel, a}) begin
      miscompares++; $display("FAIL %s request: got req=%b sel=%b addr=%h, want 1 %b %h", name, bus_req6, bus_sel6, bus_addr6, exp_sel, a);
    end
    step();
    gnt6 = 1'b0; rvalid6 = 1'b1; rdata6 = rd;
    step();
    rvalid6 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({done6, wreg_out6, exc6, wdata_out6} !== {1'b1, 1'b1, 32'h0, exp_data}) begin
      miscompares++;
      $display("FAIL %s done: got done=%b wreg=%b exc=%h data=%h, want 1 1 0 %h", name, done6, wreg_out6, exc6, wdata_out6, exp_data);
    end
    step();
  endtask

  task automatic test_xlen64();
    do_load64("ld_0x8", OP_LD, 64'h8, 64'h8000_0000_0000_0001, 8'hFF, 64'h8000_0000_0000_0001);
    do_load64("lwu_0xc", OP_LWU, 64'hC, 64'h8000_0000_0000_0001, 8'h0F, 64'h0000_0000_0000_0001);
    do_load64("lw_0x0", OP_LW, 64'h0, 64'h8000_0000_1234_5678, 8'hF0, 64'hFFFF_FFFF_8000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_exceptions();
    test_flush();
    test_reset_mid();
    test_xlen64();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
